bip_run_ctrl: RTL
=================

# bip_run_ctrl

Host-side run controller for the BIP processor system. It decodes command bytes from the UART receiver and sequences the CPU through reset, free-run or single-step by driving its enable. On completion it serialises a status/result frame back through the UART transmitter byte by byte. It sits between the UART byte interface and the CPU, taking over sequencing of the BIP enable and finish signals and of the 32-bit accumulator/PC result word.

## Interface

**Parameters**
- `MAX_CYCLES`, default 16'hFFFF: run timeout in enabled clock cycles; must be ≥ 1.

**Ports**
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx_done`  input  1  one-cycle pulse; `rx_data` holds a valid received byte.
- `rx_data`  input  8  received byte.
- `tx_start`  output  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  output  8  byte to transmit; stable from the `tx_start` cycle until `tx_done`.
- `tx_busy`  input  1  transmitter busy.
- `tx_done`  input  1  one-cycle pulse at the end of a byte.
- `cpu_rst`  output  1  one-cycle synchronous reset pulse to the CPU (PC ← 0).
- `bip_enable`  output  1  CPU/memory enable.
- `finish_program`  input  1  CPU has executed halt.
- `result`  input  32  accumulator/PC word ({5'b0, PC[10:0], ACC[15:0]}).
- `ctrl_busy`  output  1  high in any state except IDLE.

## Operation

**Commands** are sampled only in IDLE on `rx_done`. Unknown bytes, and any byte received outside IDLE, are ignored.
- 0x52 'R': reset the CPU, then run.
- 0x43 'C': continue running without reset.
- 0x53 'S': single step, exactly one enabled cycle.

**States:** IDLE, RST, RUN, STEP, LOAD, SEND, WAIT.
- IDLE: on 'R' → RST; on 'C' → RUN; on 'S' → STEP. On entering RST, RUN or STEP, clear `cycles` (16-bit).
- RST: `cpu_rst`=1 for one cycle → RUN.
- RUN: `bip_enable`=1; `cycles` increments every RUN cycle, saturating at 0xFFFF.
  - If `finish_program`=1 this cycle: status=0x00 → LOAD.
  - Else if the incremented `cycles` = `MAX_CYCLES`: status=0x01 → LOAD.
  - If finish and timeout occur together, finish wins (status 0x00).
- STEP: `bip_enable`=1 for one cycle, `cycles`=1. Status=0x00 if `finish_program`=1, else 0x02 → LOAD.
- LOAD: latch the frame from `result` sampled on the last enabled cycle. Byte index ← 0.
- Frame is 7 bytes, in order: status, result[31:24], [23:16], [15:8], [7:0], cycles[15:8], cycles[7:0].
- SEND: when `tx_busy`=0, drive `tx_data`=frame[index], pulse `tx_start` → WAIT. If `tx_busy`=1, hold in SEND.
- WAIT: on `tx_done`, if index=6 → IDLE, else index+1 → SEND.

**Reset:** from any state, all outputs are 0 the cycle after `reset` is sampled, and the state returns to IDLE. `tx_data`=0, `cycles`=0, frame=0. Reset during RUN drops `bip_enable` on the next edge. A transmission in progress is abandoned and no partial frame is resumed.

## Timing

- `rx_done`='R' at edge t:
  - `cpu_rst`=1 in cycle t+1.
  - `bip_enable`=1 from t+2.
- `rx_done`='C' or 'S' at t: `bip_enable`=1 from t+1.
- `finish_program` high in RUN cycle k: `bip_enable`=0 from k+1. `cycles` includes cycle k.
- LOAD takes one cycle. The first `tx_start` occurs no earlier than k+2.
- `tx_start` is never asserted while `tx_busy`=1, and never twice without an intervening `tx_done`.
- `bip_enable` and `tx_start` are never high in the same cycle.
- `ctrl_busy` rises on the cycle after command acceptance and falls on the cycle after the 7th `tx_done`.

## Test plan

1. **Reset values:** hold `reset` 3 cycles → all outputs 0, state IDLE. Send 0x41 → no response; `ctrl_busy` stays 0.
2. **Run to finish:** send 'R' with `finish_program` raised on the 5th enabled cycle and `result`=0x0007_0012 → `cpu_rst` pulse, `bip_enable` high exactly 5 cycles, frame 00 00 07 00 12 00 05.
3. **Timeout:** `MAX_CYCLES`=10, 'C', `finish_program` held 0 → `bip_enable` high exactly 10 cycles, no `cpu_rst`, frame 01 … 00 0A. Repeat with finish on the 10th cycle → status 00.
4. **Single step:** 'S' with `finish_program`=0 → one-cycle `bip_enable`, frame 02 … 00 01.
5. **Handshake and ignored input:** `tx_busy` held high 20 cycles after LOAD → `tx_start` withheld until it falls. Send 'R' mid-frame → ignored; exactly 7 bytes sent.
6. **Mid-operation reset:** assert `reset` during RUN cycle 3 → `bip_enable`=0 next cycle, no `tx_start`. A subsequent 'S' works normally.

Source files
------------

// File: rtl/bip_run_ctrl.sv
// bip_run_ctrl: host-side run controller for the BIP processor system.
// It decodes command bytes from the UART receiver and sequences the CPU
// through reset, free-run or single-step by driving bip_enable.
// On completion it sends a 7-byte status/result frame through the UART
// transmitter, one byte per tx_start/tx_done handshake.
`timescale 1ns/1ps

module bip_run_ctrl #(
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        cpu_rst,
  output logic        bip_enable,
  input  logic        finish_program,
  input  logic [31:0] result,
  output logic        ctrl_busy
);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    STEP,
    LOAD,
    SEND,
    WAIT
  } state_t;

  localparam logic [7:0] CMD_RESET_RUN = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CONTINUE  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP      = 8'h53;  // 'S'

  localparam logic [7:0] STATUS_FINISH  = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h01;
  localparam logic [7:0] STATUS_STEP    = 8'h02;

  localparam logic [2:0] LAST_BYTE = 3'd6;

  state_t      state;
  logic [15:0] cycles;
  logic [15:0] cycles_inc;
  logic [7:0]  status;
  logic [31:0] result_q;
  logic [2:0]  index;
  logic [7:0]  frame_byte;

  // Saturating cycle counter increment; the timeout compare uses this value.
  assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;

  // Select the frame byte for the current index from the latched run results.
  always_comb begin
    // NOTE: default assignment first so no path leaves frame_byte unassigned (no latch).
    frame_byte = 8'h00;
    unique case (index)
      3'd0:    frame_byte = status;
      3'd1:    frame_byte = result_q[31:24];
      3'd2:    frame_byte = result_q[23:16];
      3'd3:    frame_byte = result_q[15:8];
      3'd4:    frame_byte = result_q[7:0];
      3'd5:    frame_byte = cycles[15:8];
      3'd6:    frame_byte = cycles[7:0];
      default: frame_byte = 8'h00;
    endcase
  end

  // Control FSM with registered outputs: command decode, run sequencing, frame transmit.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all sequential state so every register
      // samples pre-edge values regardless of statement order.
      state      <= IDLE;
      cycles     <= 16'h0000;
      status     <= 8'h00;
      result_q   <= 32'h0000_0000;
      index      <= 3'd0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      cpu_rst    <= 1'b0;
      bip_enable <= 1'b0;
      ctrl_busy  <= 1'b0;
    end else begin
      // Pulsed outputs default low and are raised only in the cycle they fire.
      cpu_rst  <= 1'b0;
      tx_start <= 1'b0;

      unique case (state)
        IDLE: begin
          if (rx_done) begin
            case (rx_data)
              CMD_RESET_RUN: begin
                state     <= RST;
                cycles    <= 16'h0000;
                cpu_rst   <= 1'b1;
                ctrl_busy <= 1'b1;
              end
              CMD_CONTINUE: begin
                state      <= RUN;
                cycles     <= 16'h0000;
                bip_enable <= 1'b1;
                ctrl_busy  <= 1'b1;
              end
              CMD_STEP: begin
                state      <= STEP;
                cycles     <= 16'h0000;
                bip_enable <= 1'b1;
                ctrl_busy  <= 1'b1;
              end
              default: ;  // unknown bytes are ignored
            endcase
          end
        end

        RST: begin
          state      <= RUN;
          bip_enable <= 1'b1;
        end

        RUN: begin
          // Track the result every enabled cycle so the last one is what gets sent.
          cycles   <= cycles_inc;
          result_q <= result;
          if (finish_program) begin
            status     <= STATUS_FINISH;
            bip_enable <= 1'b0;
            state      <= LOAD;
          end else if (cycles_inc == MAX_CYCLES) begin
            status     <= STATUS_TIMEOUT;
            bip_enable <= 1'b0;
            state      <= LOAD;
          end
        end

        STEP: begin
          cycles     <= 16'h0001;
          result_q   <= result;
          status     <= finish_program ? STATUS_FINISH : STATUS_STEP;
          bip_enable <= 1'b0;
          state      <= LOAD;
        end

        LOAD: begin
          index <= 3'd0;
          state <= SEND;
        end

        SEND: begin
          if (!tx_busy) begin
            tx_data  <= frame_byte;
            tx_start <= 1'b1;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (tx_done) begin
            if (index == LAST_BYTE) begin
              state     <= IDLE;
              ctrl_busy <= 1'b0;
            end else begin
              index <= index + 3'd1;
              state <= SEND;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
